// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader: frame header, state encodings
// and the modulo-256 checksum helper.
package prog_loader_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_ADDR,
        LD_DATA,
        LD_CSUM,
        LD_ERROR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, start-bit glitch
// rejection; rx_valid is high in the cycle of the mid-stop-bit sample.
module prog_loader_uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       AR,
    input  logic       RXD,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_fall;
    logic            w_bit_end;

    assign w_fall    = r_prev & ~r_sync2;
    assign w_bit_end = (r_cnt == BIT_LAST);

    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
            // A start bit that reads high at mid-bit was only a glitch.
            RX_START: if (r_cnt == HALF_LAST) w_state_nxt = r_sync2 ? RX_IDLE : RX_BITS;
            RX_BITS:  if (w_bit_end && r_bit == 3'd7) w_state_nxt = RX_STOP;
            RX_STOP:  if (w_bit_end) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_state == RX_IDLE || w_state_nxt != r_state || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == RX_START) begin
                r_bit <= '0;
            end else if (r_state == RX_BITS && w_bit_end) begin
                r_shift <= {r_sync2, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

    assign rx_valid = (r_state == RX_STOP) && w_bit_end;
    assign rx_data  = r_shift;
    assign rx_ferr  = rx_valid & ~r_sync2;

endmodule

// File: rtl/prog_loader.sv
// Frame loader: parses A5/COUNT/ADDR/DATA.../CSUM from the UART, writes payload
// bytes to memory and holds the CPU in reset until a frame passes its checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic       CLK,
    input  logic       AR,
    input  logic       RXD,
    output logic [7:0] MEM_ADDR,
    output logic [7:0] MEM_DATA,
    output logic       MEM_EDIT,
    output logic       CPU_HOLD,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    ld_state_t      r_state;
    ld_state_t      w_state_nxt;
    logic [8:0]     r_remain;
    logic [7:0]     r_sum;
    logic [7:0]     r_addr;
    logic [7:0]     r_mem_addr;
    logic [7:0]     r_mem_data;
    logic           r_mem_edit;
    logic           r_hold;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [TW-1:0]  r_tmo;

    logic           w_rx_valid;
    logic [7:0]     w_rx_data;
    logic           w_rx_ferr;
    logic           w_byte_ok;
    logic           w_active;
    logic           w_hdr;
    logic           w_wr;
    logic           w_done;
    logic           w_fail;

    prog_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .CLK      (CLK),
        .AR       (AR),
        .RXD      (RXD),
        .rx_valid (w_rx_valid),
        .rx_data  (w_rx_data),
        .rx_ferr  (w_rx_ferr)
    );

    assign w_byte_ok = w_rx_valid & ~w_rx_ferr;
    assign w_active  = r_state inside {LD_COUNT, LD_ADDR, LD_DATA, LD_CSUM};

    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hdr       = 1'b0;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        w_fail      = 1'b0;
        // r_tmo counts cycles elapsed since the last byte; hitting the limit aborts.
        if (w_active && ((w_rx_valid && w_rx_ferr) || (!w_rx_valid && r_tmo == TMO_LAST))) begin
            w_fail      = 1'b1;
            w_state_nxt = LD_ERROR;
        end else begin
            case (r_state)
                LD_IDLE: begin
                    if (w_byte_ok && w_rx_data == HDR_BYTE) begin
                        w_hdr       = 1'b1;
                        w_state_nxt = LD_COUNT;
                    end
                end
                LD_COUNT: if (w_byte_ok) w_state_nxt = LD_ADDR;
                LD_ADDR:  if (w_byte_ok) w_state_nxt = LD_DATA;
                LD_DATA: begin
                    if (w_byte_ok) begin
                        w_wr = 1'b1;
                        if (r_remain == 9'd1) w_state_nxt = LD_CSUM;
                    end
                end
                LD_CSUM: begin
                    if (w_byte_ok) begin
                        if (w_rx_data == r_sum) begin
                            w_done      = 1'b1;
                            w_state_nxt = LD_IDLE;
                        end else begin
                            w_fail      = 1'b1;
                            w_state_nxt = LD_ERROR;
                        end
                    end
                end
                LD_ERROR: w_state_nxt = LD_IDLE;
                default:  w_state_nxt = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) begin
            r_remain   <= '0;
            r_sum      <= '0;
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_edit <= 1'b0;
            r_hold     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_mem_edit <= w_wr;
            r_done     <= w_done;
            if (w_rx_valid || !w_active) begin
                r_tmo <= TW'(1);
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (r_state == LD_COUNT && w_byte_ok) begin
                r_remain <= {w_rx_data == 8'h00, w_rx_data};
                r_sum    <= w_rx_data;
            end
            if (r_state == LD_ADDR && w_byte_ok) begin
                r_addr <= w_rx_data;
                r_sum  <= csum_add(r_sum, w_rx_data);
            end
            if (w_wr) begin
                r_mem_addr <= r_addr;
                r_mem_data <= w_rx_data;
                r_addr     <= r_addr + 8'd1;
                r_sum      <= csum_add(r_sum, w_rx_data);
                r_remain   <= r_remain - 9'd1;
            end
            // Error leaves CPU_HOLD set: a half-written program must not run.
            if (w_hdr) begin
                r_hold <= 1'b1;
                r_busy <= 1'b1;
                r_err  <= 1'b0;
            end else if (w_done) begin
                r_hold <= 1'b0;
                r_busy <= 1'b0;
            end else if (w_fail) begin
                r_busy <= 1'b0;
                r_err  <= 1'b1;
            end
        end
    end

    assign MEM_ADDR = r_mem_addr;
    assign MEM_DATA = r_mem_data;
    assign MEM_EDIT = r_mem_edit;
    assign CPU_HOLD = r_hold;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;

endmodule
